password_lock_controller: RTL

Sequencing controller for the serial password lock. It owns the 4-digit password store and accepts keypad events. It drives the password validator one digit at a time (enable strobe, digit, restart reset) and reacts to the validator's unlock, error and lockdown outputs. It also times lockdown release and, after a successful unlock, lets the user program a new password.

---
 rtl/password_lock_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/password_lock_controller.sv
// Keypad sequencing controller for the serial password lock: feeds digits to the
// validator, handles lockdown timing and (with PW_PROGRAM_EN defined) password reprogramming.
module password_lock_controller #(
    parameter logic [15:0] DEFAULT_PW  = 16'h1234,
    parameter int unsigned LOCK_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       keyValid,
    input  logic [3:0] keyCode,
    input  logic [1:0] vAddress,
    output logic [3:0] vData,
    output logic [3:0] vDigit,
    output logic       vEnable,
    output logic       vRstN,
    output logic       vResetLockDown,
    input  logic       vUnlock,
    input  logic       vError,
    input  logic       vLockDown,
    output logic       busy,
    output logic       unlocked,
    output logic       locked,
    output logic       pwChanged
);

    localparam int unsigned TW = $clog2(LOCK_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_RESTART,
        S_UNLOCKED,
        S_PROGRAM,
        S_COMMIT,
        S_LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    vdigit_q, vdigit_d;
    logic          vrstn_q, vrstn_d;
    logic [15:0]   pw_cur;

    logic key_digit, key_enter, key_clear;
    assign key_digit = keyValid && (keyCode < 4'd10);
    assign key_enter = keyValid && (keyCode == 4'hA);
    assign key_clear = keyValid && (keyCode == 4'hB);

`ifdef PW_PROGRAM_EN
    logic [15:0] pw_q, pw_d;
    logic [15:0] shadow_q, shadow_d;
    logic [1:0]  idx_q, idx_d;
    assign pw_cur = pw_q;
`else
    assign pw_cur = DEFAULT_PW;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            vdigit_q <= '0;
            vrstn_q  <= 1'b0;
`ifdef PW_PROGRAM_EN
            pw_q     <= DEFAULT_PW;
            shadow_q <= '0;
            idx_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            vdigit_q <= vdigit_d;
            vrstn_q  <= vrstn_d;
`ifdef PW_PROGRAM_EN
            pw_q     <= pw_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        vdigit_d = vdigit_q;
`ifdef PW_PROGRAM_EN
        pw_d     = pw_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (key_digit) begin
                    vdigit_d = keyCode;
                    state_d  = S_STROBE;
                end else if (key_clear) begin
                    state_d = S_RESTART;
                end
            end
            S_STROBE: state_d = S_WAIT;
            S_WAIT: begin
                if (vLockDown) begin
                    state_d = S_LOCKED;
                    timer_d = TW'(LOCK_CYCLES - 1);
                end else if (vUnlock) begin
                    state_d = S_UNLOCKED;
                end else if (vError) begin
                    state_d = S_RESTART;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RESTART: state_d = S_IDLE;
            S_UNLOCKED: begin
                if (key_clear) begin
                    state_d = S_RESTART;
`ifdef PW_PROGRAM_EN
                end else if (key_enter) begin
                    state_d = S_PROGRAM;
                    idx_d   = '0;
`endif
                end
            end
`ifdef PW_PROGRAM_EN
            S_PROGRAM: begin
                if (key_digit) begin
                    // index 0 is the most significant digit of the store
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (idx_q == 2'(i)) shadow_d[4*(3-i) +: 4] = keyCode;
                    end
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = S_COMMIT;
                end else if (key_clear) begin
                    shadow_d = '0;
                    state_d  = S_UNLOCKED;
                end
            end
            S_COMMIT: begin
                pw_d    = shadow_q;
                state_d = S_RESTART;
            end
`endif
            S_LOCKED: begin
                if (timer_q == '0) state_d = S_RESTART;
                else               timer_d = timer_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // vRstN is registered from the next state so its low phase coincides with RESTART
    assign vrstn_d = (state_d != S_RESTART);

    always_comb begin
        vData = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (vAddress == 2'(i)) vData = pw_cur[4*(3-i) +: 4];
        end
    end

    assign vDigit         = vdigit_q;
    assign vRstN          = vrstn_q;
    assign vEnable        = (state_q == S_STROBE);
    assign vResetLockDown = (state_q == S_LOCKED) && (timer_q == '0);
    assign busy           = (state_q == S_STROBE) || (state_q == S_WAIT) ||
                            (state_q == S_RESTART) || (state_q == S_COMMIT) ||
                            (state_q == S_LOCKED);
    assign unlocked       = (state_q == S_UNLOCKED) || (state_q == S_PROGRAM);
    assign locked         = (state_q == S_LOCKED);
`ifdef PW_PROGRAM_EN
    assign pwChanged      = (state_q == S_COMMIT);
`else
    assign pwChanged      = 1'b0;
`endif

endmodule
